// File: rtl/fifo_packer_pkg.sv
// Shared types and sizes for the FIFO byte packer and its idle timer.
package fifo_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_e;

  localparam int unsigned PK_BYTES  = 4;
  localparam int unsigned PK_LANE_W = 8;
  localparam int unsigned PK_WORD_W = PK_BYTES * PK_LANE_W;
  localparam int unsigned PK_CNT_W  = 3;

endpackage

// File: rtl/packer_idle_timer.sv
// Idle-cycle counter for partial-word flush; emits a one-cycle expiry pulse
// after LIMIT consecutive enabled cycles. Used only under PACKER_TIMEOUT_EN.
module packer_idle_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expire_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count_q, count_d;
  logic       hit;

  assign hit      = count_en_i & ~clear_i & (count_q == LAST);
  assign expire_o = hit;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i || hit) count_d = '0;
    else if (count_en_i) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains the byte FIFO and packs four bytes into a little-endian 32-bit word
// on a valid/ready port. Optional partial-word flush under PACKER_TIMEOUT_EN.
module fifo_byte_packer
  import fifo_packer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 SYSCLK,
  input  logic                 RST_B,
  input  logic [PK_LANE_W-1:0] FIFO_DATA,
  input  logic                 FIFO_EMPTY,
  input  logic                 FIFO_FULL,
  input  logic                 FIFO_WR_EN,
  output logic                 FIFO_RD_EN,
  output logic [PK_WORD_W-1:0] WORD_OUT,
  output logic [2:0]           WORD_BYTES,
  output logic                 WORD_VALID,
  input  logic                 WORD_READY
);

  pk_state_e            state_q;
  logic [PK_CNT_W-1:0]  cnt_q, cnt_d;
  logic                 pend_q;
  logic [PK_WORD_W-1:0] word_q;
  logic [2:0]           bytes_q;
  logic                 valid_q;
  logic                 accept;
  logic                 timeout_hit;

  // In-flight read counts against capacity so the FIFO is never over-drained.
  assign FIFO_RD_EN = (state_q == FILL) & RST_B & ~FIFO_EMPTY &
                      ((cnt_q + {2'b00, pend_q}) < 3'(PK_BYTES));
  // The FIFO services a write instead of a read when both are requested.
  assign accept     = FIFO_RD_EN & ~FIFO_EMPTY & ~(FIFO_WR_EN & ~FIFO_FULL);
  assign cnt_d      = cnt_q + 3'd1;

  assign WORD_OUT   = word_q;
  assign WORD_BYTES = bytes_q;
  assign WORD_VALID = valid_q;

`ifdef PACKER_TIMEOUT_EN
  logic idle_en, idle_clr;

  assign idle_en  = (state_q == FILL) & (cnt_q != '0) & ~pend_q & ~accept;
  assign idle_clr = accept | (state_q != FILL) | (cnt_q == '0);

  packer_idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk       (SYSCLK),
    .rst_n     (RST_B),
    .clear_i   (idle_clr),
    .count_en_i(idle_en),
    .expire_o  (timeout_hit)
  );
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge SYSCLK) begin
    if (!RST_B) begin
      // NOTE: the lane register is a datapath store but is reset here because
      // a discarded partial word must never leak into the next one.
      state_q <= FILL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      word_q  <= '0;
      bytes_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q <= accept;
      case (state_q)
        FILL: begin
          if (pend_q) begin
            word_q[{cnt_q[1:0], 3'b000} +: PK_LANE_W] <= FIFO_DATA;
            cnt_q <= cnt_d;
            if (cnt_d == 3'(PK_BYTES)) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
              bytes_q <= cnt_d;
            end
          end else if (timeout_hit) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            bytes_q <= cnt_q;
          end
        end
        HOLD: begin
          if (WORD_READY) begin
            state_q <= FILL;
            cnt_q   <= '0;
            word_q  <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_byte_packer.md
# fifo_byte_packer

Downstream drain stage for the 8-bit byte FIFO. It pops bytes from the FIFO read port, packs four consecutive bytes into one 32-bit little-endian word, and offers the word on a valid/ready interface to the next stage. It accounts for the FIFO's one-cycle registered read latency and its write-over-read priority, so no byte is lost or duplicated.

## Interface
- `TIMEOUT_CYCLES`, default 16: idle cycles before a partial word is flushed (used only with `PACKER_TIMEOUT_EN`; minimum 2, maximum 255).
- `SYSCLK` in 1: single clock; all logic on the rising edge.
- `RST_B` in 1: reset, synchronous, active-low.
- `FIFO_DATA` in 8: FIFO read data, registered inside the FIFO, valid the cycle after an accepted read.
- `FIFO_EMPTY` in 1: FIFO empty flag.
- `FIFO_FULL` in 1: FIFO full flag.
- `FIFO_WR_EN` in 1: FIFO write enable, monitored to qualify read acceptance.
- `FIFO_RD_EN` out 1: FIFO read request.
- `WORD_OUT` out 32: packed word; byte 0 (first popped) in [7:0], byte 3 in [31:24].
- `WORD_BYTES` out 3: number of valid bytes in `WORD_OUT` (1–4).
- `WORD_VALID` out 1: word offered.
- `WORD_READY` in 1: consumer accepts the word.

## Operation
- States:
  - FILL: collecting bytes.
  - HOLD: word offered.
- Read acceptance:
  - accept = `FIFO_RD_EN` & ~`FIFO_EMPTY` & ~(`FIFO_WR_EN` & ~`FIFO_FULL`).
  - The FIFO gives writes priority, so a request with no accept returns nothing.
- `FIFO_RD_EN` is combinational: high iff state = FILL, `RST_B` = 1, ~`FIFO_EMPTY`, and cnt + pend < 4.
- `pend` (1 bit) <= accept. When `pend` = 1, `FIFO_DATA` is written into byte lane cnt and cnt (3 bits, 0–4) increments.
- A request that is not accepted is simply reissued the next cycle. Data present while `pend` = 0 is ignored.
- FILL -> HOLD when the capture brings cnt to 4. `WORD_VALID` <= 1 and `WORD_BYTES` <= 4. No reads are issued in HOLD.
- HOLD -> FILL when `WORD_VALID` & `WORD_READY`:
  - cnt, all byte lanes and `WORD_BYTES` clear to 0.
  - `WORD_VALID` <= 0.
- In HOLD, `WORD_OUT` and `WORD_BYTES` are stable until the handshake. `WORD_VALID` never drops without `WORD_READY`.
- Reset (any cycle, including mid-word or in HOLD) discards the partial word and `pend`:
  - state goes to FILL;
  - `WORD_OUT` = 0, `WORD_BYTES` = 0, `WORD_VALID` = 0, `FIFO_RD_EN` = 0.

## Timing
- An accepted read in cycle t is captured at the end of cycle t+1.
- Back-to-back reads are allowed: one byte per cycle while the FIFO is non-empty.
- Minimum latency: first accepted read in cycle t gives `WORD_VALID` high in cycle t+5 (four reads in t..t+3, last capture at the end of t+4).
- Throughput: the handshake in cycle h allows the next `FIFO_RD_EN` in cycle h+1.
- `WORD_READY` is permitted to be held high continuously; each word is then offered for exactly one cycle.
- `FIFO_RD_EN` depends combinationally only on state, counters, `FIFO_EMPTY` and `RST_B`. It has no path from `WORD_READY`.

## Configuration
- `PACKER_TIMEOUT_EN` defined:
  - An idle counter runs in FILL while cnt > 0, `pend` = 0 and no accept occurs. Any accept clears it.
  - When it reaches `TIMEOUT_CYCLES` the block moves to HOLD:
    - `WORD_OUT` carries the collected lanes, with unused upper lanes zero;
    - `WORD_BYTES` = cnt.
  - It does not start while cnt = 0.
- `PACKER_TIMEOUT_EN` undefined:
  - No idle counter; partial words wait indefinitely.
  - `WORD_BYTES` is always 4 when valid and 0 otherwise.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `fifo_packer_pkg`:
  - state enum (FILL, HOLD);
  - `PK_BYTES` = 4;
  - `PK_LANE_W` = 8;
  - `PK_WORD_W` = 32.
- Sub-module `packer_idle_timer`:
  - inputs: clear, count enable;
  - output: one-cycle expiry pulse;
  - instantiated only under `PACKER_TIMEOUT_EN`.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 into the FIFO, then 0x44 once space frees -> `WORD_OUT` = 0x44332211, `WORD_BYTES` = 4, `WORD_VALID` held until `WORD_READY`.
- FIFO pre-filled with 3 bytes, `WORD_READY` = 1 throughout, a 4th byte written later -> exactly one word, one-cycle `WORD_VALID`, and no `FIFO_RD_EN` while `FIFO_EMPTY`.
- `FIFO_WR_EN` = 1 (FIFO not full) in the same cycle as `FIFO_RD_EN` -> read not accepted and reissued the next cycle; the resulting word has no duplicated or missing byte.
- `WORD_READY` = 0 for 10 cycles in HOLD with the FIFO non-empty -> `FIFO_RD_EN` = 0 and `WORD_OUT` stable; after the handshake, reads resume in the next cycle.
- `RST_B` = 0 after 2 bytes captured -> all outputs 0. The next 4 bytes form a clean word, with no stale lanes.
- With `PACKER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16: push 0xAA, 0xBB, then idle -> after 16 idle cycles `WORD_OUT` = 0x0000BBAA, `WORD_BYTES` = 2.
